// File: rtl/idecode_sb.sv
// idecode_sb: decode stage between IF and EX with a register scoreboard.
// Splits the instruction, expands the immediate, one-hot decodes the opcode
// and registers the operands for EX. Destinations are reserved on issue and
// released by the WB port; IF is stalled on RAW/WAW hazards or EX back-pressure.
// Optional feature macro: IDECODE_SB_BYPASS_EN (WB-to-decode bypass).
module idecode_sb #(
   parameter int unsigned          WORD      = 32,
   parameter int unsigned          W_OPC     = 4,
   parameter int unsigned          W_REG     = 4,
   parameter int unsigned          W_IMM     = 16,
   parameter logic [2**W_OPC-1:0]  NOWB_MASK = 16'h0000,
   parameter logic [2**W_OPC-1:0]  SEXT_MASK = 16'hFFFF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 v_i,
   input  logic [WORD-1:0]      inst_i,
   output logic                 stall_o,
   output logic [W_REG-1:0]     r0_num_o,
   output logic [W_REG-1:0]     r1_num_o,
   input  logic [WORD-1:0]      r0_data_i,
   input  logic [WORD-1:0]      r1_data_i,
   input  logic                 wb_v_i,
   input  logic [W_REG-1:0]     wb_num_i,
   input  logic [WORD-1:0]      wb_data_i,
   output logic                 v_o,
   input  logic                 stall_i,
   output logic [WORD-1:0]      src_o,
   output logic [WORD-1:0]      dest_o,
   output logic [W_REG-1:0]     rd_num_o,
   output logic [2**W_OPC-1:0]  dopc_o,
   output logic                 wb_o,
   output logic [2**W_REG-1:0]  busy_o
);

   localparam int unsigned NREG   = 2**W_REG;
   localparam int unsigned NOPC   = 2**W_OPC;
   localparam int unsigned P_IMMF = WORD - W_OPC - 1;
   localparam int unsigned P_RD   = P_IMMF - 1;
   localparam int unsigned P_RS   = P_RD - W_REG;

   logic [W_OPC-1:0] w_opc;
   logic             w_immf;
   logic [W_REG-1:0] w_rd;
   logic [W_REG-1:0] w_rs;
   logic [W_IMM-1:0] w_imm;
   logic [WORD-1:0]  w_imm_ext;
   logic [WORD-1:0]  w_rd_data;
   logic [WORD-1:0]  w_rs_data;
   logic             w_byp_rd;
   logic             w_byp_rs;
   logic             w_busy_rd;
   logic             w_busy_rs;
   logic             w_hold;
   logic             w_hazard;
   logic             w_accept;
   logic             w_wb;
   logic [NOPC-1:0]  w_dopc;
   logic [NREG-1:0]  w_busy_nxt;
   logic             w_unused;

   logic             r_v;
   logic [WORD-1:0]  r_src;
   logic [WORD-1:0]  r_dest;
   logic [W_REG-1:0] r_rd;
   logic [NOPC-1:0]  r_dopc;
   logic             r_wb;
   logic [NREG-1:0]  r_busy;

   assign w_opc  = inst_i[WORD-1 -: W_OPC];
   assign w_immf = inst_i[P_IMMF];
   assign w_rd   = inst_i[P_RD -: W_REG];
   assign w_rs   = inst_i[P_RS -: W_REG];
   assign w_imm  = inst_i[W_IMM-1:0];

   // Field bits outside opc/immf/rd/rs/imm are reserved; wb_data_i is only
   // consumed when the bypass is built in.
   assign w_unused = ^{inst_i, wb_data_i};

`ifdef IDECODE_SB_BYPASS_EN
   // A retiring write to an operand index both frees it for the hazard check
   // and supplies its value directly, saving a cycle per RAW dependency.
   assign w_byp_rd  = wb_v_i & (wb_num_i == w_rd);
   assign w_byp_rs  = wb_v_i & (wb_num_i == w_rs);
   assign w_rd_data = w_byp_rd ? wb_data_i : r0_data_i;
   assign w_rs_data = w_byp_rs ? wb_data_i : r1_data_i;
`else
   assign w_byp_rd  = 1'b0;
   assign w_byp_rs  = 1'b0;
   assign w_rd_data = r0_data_i;
   assign w_rs_data = r1_data_i;
`endif

   assign w_busy_rd = r_busy[w_rd] & ~w_byp_rd;
   assign w_busy_rs = r_busy[w_rs] & ~w_byp_rs;

   assign w_hold   = r_v & stall_i;
   assign w_hazard = v_i & (w_busy_rd | (~w_immf & w_busy_rs));
   assign stall_o  = v_i & (w_hazard | w_hold);
   assign w_accept = v_i & ~stall_o;

   assign r0_num_o = w_rd;
   assign r1_num_o = w_rs;

   assign w_imm_ext = SEXT_MASK[w_opc] ? {{(WORD-W_IMM){w_imm[W_IMM-1]}}, w_imm}
                                       : {{(WORD-W_IMM){1'b0}}, w_imm};
   assign w_wb      = ~NOWB_MASK[w_opc];

   // One-hot opcode decode
   always_comb begin
      w_dopc        = '0;
      w_dopc[w_opc] = 1'b1;
   end

   // Scoreboard next state: clear from WB first so a same-cycle reservation wins
   always_comb begin
      w_busy_nxt = r_busy;
      if (wb_v_i)
         w_busy_nxt[wb_num_i] = 1'b0;
      if (w_accept & w_wb)
         w_busy_nxt[w_rd] = 1'b1;
   end

   // Scoreboard register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   // EX output registers: frozen under hold, bubble when nothing is accepted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v    <= 1'b0;
         r_src  <= '0;
         r_dest <= '0;
         r_rd   <= '0;
         r_dopc <= '0;
         r_wb   <= 1'b0;
      end else if (!w_hold) begin
         r_v <= w_accept;
         if (w_accept) begin
            r_src  <= w_immf ? w_imm_ext : w_rs_data;
            r_dest <= w_rd_data;
            r_rd   <= w_rd;
            r_dopc <= w_dopc;
            r_wb   <= w_wb;
         end
      end
   end

   assign v_o      = r_v;
   assign src_o    = r_src;
   assign dest_o   = r_dest;
   assign rd_num_o = r_rd;
   assign dopc_o   = r_dopc;
   assign wb_o     = r_wb;
   assign busy_o   = r_busy;

endmodule

// File: tb/tb_idecode_sb.sv
// Testbench for idecode_sb: directed scenarios plus a randomized run, all
// checked against a cycle-level reference model of the decode/scoreboard rules.
module tb_idecode_sb;

   localparam logic [15:0] NOWB = 16'h8000;  // opcode 15 does not write back
   localparam logic [15:0] SEXT = 16'hFEFF;  // opcode 8 zero-extends

   logic        clk = 1'b0;
   logic        rst;
   logic        v_i;
   logic [31:0] inst_i;
   logic        stall_o;
   logic [3:0]  r0_num_o, r1_num_o;
   logic [31:0] r0_data_i, r1_data_i;
   logic        wb_v_i;
   logic [3:0]  wb_num_i;
   logic [31:0] wb_data_i;
   logic        v_o;
   logic        stall_i;
   logic [31:0] src_o, dest_o;
   logic [3:0]  rd_num_o;
   logic [15:0] dopc_o;
   logic        wb_o;
   logic [15:0] busy_o;

   logic [31:0] rf [16];
   int          n_cmp = 0;
   int          n_err = 0;

   // reference model state
   logic        m_v;
   logic [31:0] m_src, m_dest;
   logic [3:0]  m_rd;
   logic [15:0] m_dopc;
   logic        m_wb;
   logic [15:0] m_busy;
   bit          e_stall, e_accept, e_hold;

   idecode_sb #(
      .WORD(32), .W_OPC(4), .W_REG(4), .W_IMM(16),
      .NOWB_MASK(NOWB), .SEXT_MASK(SEXT)
   ) dut (
      .clk(clk), .rst(rst), .v_i(v_i), .inst_i(inst_i), .stall_o(stall_o),
      .r0_num_o(r0_num_o), .r1_num_o(r1_num_o),
      .r0_data_i(r0_data_i), .r1_data_i(r1_data_i),
      .wb_v_i(wb_v_i), .wb_num_i(wb_num_i), .wb_data_i(wb_data_i),
      .v_o(v_o), .stall_i(stall_i), .src_o(src_o), .dest_o(dest_o),
      .rd_num_o(rd_num_o), .dopc_o(dopc_o), .wb_o(wb_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   assign r0_data_i = rf[r0_num_o];
   assign r1_data_i = rf[r1_num_o];

   function automatic logic [31:0] mk(input logic [3:0] opc, input logic immf,
                                      input logic [3:0] rd, input logic [3:0] rs,
                                      input logic [15:0] imm);
      return {opc, immf, rd, rs, 3'b000, imm};
   endfunction

   // value an operand register presents at decode (register file or bypassed WB)
   function automatic logic [31:0] operand(input logic [3:0] idx);
`ifdef IDECODE_SB_BYPASS_EN
      if (wb_v_i && wb_num_i == idx) return wb_data_i;
`endif
      return rf[idx];
   endfunction

   function automatic bit is_busy(input logic [3:0] idx);
`ifdef IDECODE_SB_BYPASS_EN
      if (wb_v_i && wb_num_i == idx) return 1'b0;
`endif
      return m_busy[idx];
   endfunction

   task automatic model_reset();
      m_v = 0; m_src = '0; m_dest = '0; m_rd = '0; m_dopc = '0; m_wb = 0; m_busy = '0;
   endtask

   task automatic model_eval();
      logic [3:0] rd, rs;
      logic immf;
      rd = inst_i[26:23]; rs = inst_i[22:19]; immf = inst_i[27];
      e_hold   = m_v && stall_i;
      e_stall  = v_i && (is_busy(rd) || (!immf && is_busy(rs)) || e_hold);
      e_accept = v_i && !e_stall;
   endtask

   task automatic model_commit();
      int opc;
      logic [3:0] rd, rs;
      logic [15:0] imm;
      bit writes;
      opc = int'(inst_i[31:28]); rd = inst_i[26:23]; rs = inst_i[22:19]; imm = inst_i[15:0];
      writes = !NOWB[opc];
      if (!e_hold) begin
         m_v = e_accept;
         if (e_accept) begin
            if (inst_i[27]) m_src = SEXT[opc] ? 32'($signed(imm)) : 32'(imm);
            else            m_src = operand(rs);
            m_dest = operand(rd);
            m_rd   = rd;
            m_dopc = 16'(1) << opc;
            m_wb   = writes;
         end
      end
      if (wb_v_i) m_busy[wb_num_i] = 1'b0;
      if (e_accept && writes) m_busy[rd] = 1'b1;
   endtask

   task automatic apply(input bit v, input logic [31:0] inst, input bit st,
                        input bit wv, input logic [3:0] wn, input logic [31:0] wd);
      v_i = v; inst_i = inst; stall_i = st; wb_v_i = wv; wb_num_i = wn; wb_data_i = wd;
      #1;
      model_eval();
   endtask

   task automatic step();
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   // retire every outstanding reservation, then idle one cycle
   task automatic drain();
      for (int k = 0; k < 16; k++) begin
         if (m_busy[k]) begin
            apply(0, '0, 0, 1, 4'(k), '0);
            step();
         end
      end
      apply(0, '0, 0, 0, '0, '0);
      step();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      apply(1, mk(1, 0, 3, 4, 0), 0, 0, '0, '0);
      n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL reset_v: got %b exp 0", v_o); end
      n_cmp++; if (busy_o !== 16'h0) begin n_err++; $display("FAIL reset_busy: got %h exp 0000", busy_o); end
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b exp 0", stall_o); end
      n_cmp++; if ({src_o, dest_o, rd_num_o, dopc_o, wb_o} !== '0) begin n_err++; $display("FAIL reset_regs: got %h/%h/%h/%h/%b exp 0", src_o, dest_o, rd_num_o, dopc_o, wb_o); end
      @(posedge clk); @(negedge clk);
      n_cmp++; if (v_o !== 1'b0 || busy_o !== 16'h0) begin n_err++; $display("FAIL reset_held: got v=%b busy=%h exp 0/0000", v_o, busy_o); end
      rst = 1'b1;
      apply(0, '0, 0, 0, '0, '0);
      step();
   endtask

   task automatic test_stream();
      for (int i = 1; i <= 4; i++) begin
         apply(1, mk(0, 0, 4'(i), 4'(i + 8), 0), 0, 0, '0, '0);
         n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL stream_stall%0d: got %b exp 0", i, stall_o); end
         step();
         n_cmp++; if (v_o !== 1'b1 || rd_num_o !== 4'(i)) begin n_err++; $display("FAIL stream_issue%0d: got v=%b rd=%0d exp 1/%0d", i, v_o, rd_num_o, i); end
         n_cmp++; if (src_o !== rf[i+8] || dest_o !== rf[i] || dopc_o !== 16'h0001) begin n_err++; $display("FAIL stream_data%0d: got %h/%h/%h exp %h/%h/0001", i, src_o, dest_o, dopc_o, rf[i+8], rf[i]); end
      end
      apply(0, '0, 0, 0, '0, '0);
      n_cmp++; if (busy_o !== 16'h001E) begin n_err++; $display("FAIL stream_busy: got %h exp 001e", busy_o); end
      step();
      n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL stream_bubble: got %b exp 0", v_o); end
      drain();
   endtask

   task automatic test_raw();
      logic [31:0] wd;
      wd = 32'hA5A5_1234;
      apply(1, mk(0, 0, 3, 1, 0), 0, 0, '0, '0);
      step();
      apply(1, mk(1, 0, 6, 3, 0), 0, 0, '0, '0);
      n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL raw_stall: got %b exp 1", stall_o); end
      step();
      n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL raw_bubble: got %b exp 0", v_o); end
      step();
      apply(1, mk(1, 0, 6, 3, 0), 0, 1, 4'd3, wd);
`ifdef IDECODE_SB_BYPASS_EN
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL raw_byp_stall: got %b exp 0", stall_o); end
      step();
      n_cmp++; if (v_o !== 1'b1 || src_o !== wd) begin n_err++; $display("FAIL raw_byp_issue: got v=%b src=%h exp 1/%h", v_o, src_o, wd); end
`else
      n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL raw_wb_stall: got %b exp 1", stall_o); end
      step();
      apply(1, mk(1, 0, 6, 3, 0), 0, 0, '0, '0);
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL raw_release: got %b exp 0", stall_o); end
      step();
      n_cmp++; if (v_o !== 1'b1 || src_o !== rf[3]) begin n_err++; $display("FAIL raw_issue: got v=%b src=%h exp 1/%h", v_o, src_o, rf[3]); end
`endif
      drain();
   endtask

   task automatic test_ex_stall();
      apply(1, mk(4, 1, 7, 8, 16'h1234), 0, 0, '0, '0);
      step();
      n_cmp++; if (v_o !== 1'b1) begin n_err++; $display("FAIL exst_first: got %b exp 1", v_o); end
      apply(1, mk(5, 0, 9, 10, 0), 1, 0, '0, '0);
      n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL exst_stall: got %b exp 1", stall_o); end
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++; if (v_o !== 1'b1 || src_o !== 32'h1234 || dopc_o !== 16'h0010) begin n_err++; $display("FAIL exst_hold%0d: got v=%b src=%h dopc=%h exp 1/00001234/0010", i, v_o, src_o, dopc_o); end
      end
      apply(1, mk(5, 0, 9, 10, 0), 0, 0, '0, '0);
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL exst_release: got %b exp 0", stall_o); end
      step();
      n_cmp++; if (rd_num_o !== 4'd9 || dopc_o !== 16'h0020 || src_o !== rf[10]) begin n_err++; $display("FAIL exst_next: got rd=%0d dopc=%h src=%h exp 9/0020/%h", rd_num_o, dopc_o, src_o, rf[10]); end
      drain();
   endtask

   task automatic test_imm();
      apply(1, mk(2, 1, 11, 0, 16'hFFFE), 0, 0, '0, '0);
      step();
      n_cmp++; if (src_o !== 32'hFFFF_FFFE || dopc_o !== 16'h0004) begin n_err++; $display("FAIL imm_sext: got src=%h dopc=%h exp fffffffe/0004", src_o, dopc_o); end
      apply(1, mk(8, 1, 12, 0, 16'hFFFE), 0, 0, '0, '0);
      step();
      n_cmp++; if (src_o !== 32'h0000_FFFE || dopc_o !== 16'h0100) begin n_err++; $display("FAIL imm_zext: got src=%h dopc=%h exp 0000fffe/0100", src_o, dopc_o); end
      drain();
   endtask

   task automatic test_setclr();
      apply(1, mk(3, 0, 5, 13, 0), 0, 1, 4'd5, '0);
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL sc_stall: got %b exp 0", stall_o); end
      step();
      n_cmp++; if (busy_o !== 16'h0020) begin n_err++; $display("FAIL sc_setwins: got %h exp 0020", busy_o); end
      apply(1, mk(15, 0, 6, 14, 0), 0, 0, '0, '0);
      step();
      n_cmp++; if (v_o !== 1'b1 || wb_o !== 1'b0 || busy_o !== 16'h0020) begin n_err++; $display("FAIL sc_nowb: got v=%b wb=%b busy=%h exp 1/0/0020", v_o, wb_o, busy_o); end
      apply(0, '0, 0, 1, 4'd9, '0);
      step();
      n_cmp++; if (busy_o !== 16'h0020) begin n_err++; $display("FAIL sc_idleclr: got %h exp 0020", busy_o); end
      drain();
   endtask

   task automatic test_midreset();
      apply(1, mk(0, 0, 2, 8, 0), 0, 0, '0, '0);
      step();
      apply(1, mk(0, 0, 4, 8, 0), 0, 0, '0, '0);
      step();
      apply(0, '0, 0, 0, '0, '0);
      n_cmp++; if (busy_o !== 16'h0014) begin n_err++; $display("FAIL mr_pre: got %h exp 0014", busy_o); end
      #1 rst = 1'b0;
      #1;
      model_reset();
      n_cmp++; if (busy_o !== 16'h0 || v_o !== 1'b0) begin n_err++; $display("FAIL mr_async: got busy=%h v=%b exp 0000/0", busy_o, v_o); end
      @(negedge clk);
      rst = 1'b1;
      apply(0, '0, 0, 1, 4'd2, '0);
      step();
      n_cmp++; if (busy_o !== 16'h0) begin n_err++; $display("FAIL mr_latewb: got %h exp 0000", busy_o); end
   endtask

   task automatic test_random();
      int cand[$];
      bit wv;
      logic [3:0] wn;
      logic [31:0] inst;
      for (int c = 0; c < 400; c++) begin
         cand.delete();
         for (int k = 0; k < 16; k++) if (m_busy[k]) cand.push_back(k);
         wv = 0; wn = 4'($urandom);
         if (cand.size() > 0 && ($urandom % 3) == 0) begin
            wv = 1; wn = 4'(cand[$urandom % cand.size()]);
         end
         inst = $urandom;
         apply(($urandom % 4) != 0, inst, ($urandom % 4) == 0, wv, wn, $urandom);
         n_cmp++; if (stall_o !== e_stall) begin n_err++; $display("FAIL rnd_stall c%0d: got %b exp %b", c, stall_o, e_stall); end
         n_cmp++; if (r0_num_o !== inst[26:23] || r1_num_o !== inst[22:19]) begin n_err++; $display("FAIL rnd_num c%0d: got %0d/%0d exp %0d/%0d", c, r0_num_o, r1_num_o, inst[26:23], inst[22:19]); end
         step();
         n_cmp++; if (v_o !== m_v || busy_o !== m_busy) begin n_err++; $display("FAIL rnd_state c%0d: got v=%b busy=%h exp %b/%h", c, v_o, busy_o, m_v, m_busy); end
         if (m_v) begin
            n_cmp++; if ({src_o, dest_o, rd_num_o, dopc_o, wb_o} !== {m_src, m_dest, m_rd, m_dopc, m_wb}) begin n_err++; $display("FAIL rnd_data c%0d: got %h/%h/%0d/%h/%b exp %h/%h/%0d/%h/%b", c, src_o, dest_o, rd_num_o, dopc_o, wb_o, m_src, m_dest, m_rd, m_dopc, m_wb); end
         end
      end
      drain();
   endtask

   initial begin
      for (int k = 0; k < 16; k++) rf[k] = $urandom;
      test_reset();
      test_stream();
      test_raw();
      test_ex_stall();
      test_imm();
      test_setclr();
      test_midreset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
